// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: derived widths, read-mode constants and
// error-flag bit positions used by both the single- and dual-clock FIFOs.
package fifo_pkg;

    // Read-mode selector values for the FWFT parameter
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Bit positions of the sticky error flags inside the error vector
    localparam int ERR_WR_BIT = 0;
    localparam int ERR_RD_BIT = 1;
    localparam int ERR_BITS   = 2;

    // Memory address width for a power-of-two depth
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer/count width: address bits plus one wrap bit so that
    // full and empty can be told apart
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer-side bundle of the single-clock programmable FIFO.
// The slave modport is the FIFO itself; the master is whatever drives it.
interface sync_fifo_prog_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = cnt_width(DEPTH);

    logic             wr_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] rdata_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic [CW-1:0]    count_o;
    logic [CW-1:0]    afull_thr_i;
    logic [CW-1:0]    aempty_thr_i;
    logic             err_clr_i;
    logic             wr_error_o;
    logic             rd_error_o;

    modport master (
        output wr_en_i, wdata_i, rd_en_i, afull_thr_i, aempty_thr_i, err_clr_i,
        input  rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, wr_error_o, rd_error_o
    );

    modport slave (
        input  wr_en_i, wdata_i, rd_en_i, afull_thr_i, aempty_thr_i, err_clr_i,
        output rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, wr_error_o, rd_error_o
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port, so the FIFO can offer both registered and
// fall-through read data from the same storage.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; only accepted writes touch it
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with live occupancy, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and selectable
// first-word-fall-through read mode.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int FWFT  = MODE_STD
) (
    input  logic            clk_i,
    input  logic            clr_i,
    sync_fifo_prog_if.slave bus
);
    localparam int CW = cnt_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    logic [CW-1:0]       wr_ptr;
    logic [CW-1:0]       rd_ptr;
    logic [CW-1:0]       wr_ptr_n;
    logic [CW-1:0]       rd_ptr_n;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_n;
    logic                full_q;
    logic                empty_q;
    logic                afull_q;
    logic                aempty_q;
    logic [ERR_BITS-1:0] err_q;
    logic [ERR_BITS-1:0] err_set;
    logic [WIDTH-1:0]    mem_rdata;
    logic [WIDTH-1:0]    rdata_q;
    logic                wa;
    logic                ra;

    // A request is only honoured when the registered flag allows it, so a
    // full FIFO never passes through and an empty one never bypasses
    assign wa = bus.wr_en_i & ~full_q;
    assign ra = bus.rd_en_i & ~empty_q;

    assign wr_ptr_n = wr_ptr + CW'(wa);
    assign rd_ptr_n = rd_ptr + CW'(ra);
    assign count_n  = wr_ptr_n - rd_ptr_n;

    // Refused requests raise the matching error bit for this cycle
    always_comb begin
        err_set             = '0;
        err_set[ERR_WR_BIT] = bus.wr_en_i & full_q;
        err_set[ERR_RD_BIT] = bus.rd_en_i & empty_q;
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wa),
        .waddr_i (wr_ptr[AW-1:0]),
        .wdata_i (bus.wdata_i),
        .raddr_i (rd_ptr[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Pointers, registered flags from next-state count, sticky errors and
    // the read-data register (set beats clear on the error flags)
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count_q  <= count_n;
            full_q   <= (count_n == CW'(DEPTH));
            empty_q  <= (count_n == '0);
            afull_q  <= (count_n >= bus.afull_thr_i);
            aempty_q <= (count_n <= bus.aempty_thr_i);
            err_q    <= err_set | (err_q & ~{ERR_BITS{bus.err_clr_i}});
            if (ra) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // In fall-through mode the head word is shown live; rdata_q then only
    // acts as the shadow that holds the last popped word while empty
    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            assign bus.rdata_o = empty_q ? rdata_q : mem_rdata;
        end else begin : g_std
            assign bus.rdata_o = rdata_q;
        end
    endgenerate

    assign bus.full_o         = full_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_full_o  = afull_q;
    assign bus.almost_empty_o = aempty_q;
    assign bus.count_o        = count_q;
    assign bus.wr_error_o     = err_q[ERR_WR_BIT];
    assign bus.rd_error_o     = err_q[ERR_RD_BIT];

endmodule
